// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and message decryptor: walks i/j through the shuffled
// S memory, swaps entries, and XORs each keystream byte with the encrypted ROM.
module rc4_prga_decrypt #(
   parameter int MSG_LEN = 32,
   parameter int K_W     = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   output logic           done,
   output logic [7:0]     s_addr,
   input  logic [7:0]     s_rdata,
   output logic [7:0]     s_wdata,
   output logic           s_wren,
   output logic [K_W-1:0] enc_addr,
   input  logic [7:0]     enc_rdata,
   output logic [K_W-1:0] dec_addr,
   output logic [7:0]     dec_wdata,
   output logic           dec_wren
);

   localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

   typedef enum logic [3:0] {
      IDLE,
      RD_I,
      LAT_I,
      RD_J,
      LAT_J,
      WR_I,
      WR_J,
      RD_F,
      LAT_F,
      WR_D,
      DONE
   } state_t;

   state_t         state, state_nxt;
   logic [7:0]     i, i_nxt;
   logic [7:0]     j, j_nxt;
   logic [K_W-1:0] k, k_nxt;
   logic [7:0]     si, si_nxt;
   logic [7:0]     sj, sj_nxt;
   logic [7:0]     f, f_nxt;
   logic [7:0]     enc_byte, enc_byte_nxt;

   logic           done_nxt;
   logic [7:0]     s_addr_nxt;
   logic [7:0]     s_wdata_nxt;
   logic           s_wren_nxt;
   logic [K_W-1:0] enc_addr_nxt;
   logic [K_W-1:0] dec_addr_nxt;
   logic [7:0]     dec_wdata_nxt;
   logic           dec_wren_nxt;

   // Next-state and working-register updates
   always_comb begin
      state_nxt    = state;
      i_nxt        = i;
      j_nxt        = j;
      k_nxt        = k;
      si_nxt       = si;
      sj_nxt       = sj;
      f_nxt        = f;
      enc_byte_nxt = enc_byte;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               i_nxt     = 8'd1;
               j_nxt     = 8'd0;
               k_nxt     = '0;
               state_nxt = RD_I;
            end
         end
         RD_I:  state_nxt = LAT_I;
         LAT_I: begin
            si_nxt    = s_rdata;
            j_nxt     = j + s_rdata;
            state_nxt = RD_J;
         end
         RD_J:  state_nxt = LAT_J;
         LAT_J: begin
            sj_nxt    = s_rdata;
            state_nxt = WR_I;
         end
         WR_I:  state_nxt = WR_J;
         WR_J:  state_nxt = RD_F;
         RD_F:  state_nxt = LAT_F;
         LAT_F: begin
            f_nxt        = s_rdata;
            enc_byte_nxt = enc_rdata;
            state_nxt    = WR_D;
         end
         WR_D: begin
            if (k == K_LAST) begin
               state_nxt = DONE;
            end else begin
               k_nxt     = k + K_W'(1);
               i_nxt     = i + 8'd1;
               state_nxt = RD_I;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the state being entered so they can be registered
   // and still appear during that state.
   always_comb begin
      done_nxt      = 1'b0;
      s_addr_nxt    = 8'd0;
      s_wdata_nxt   = 8'd0;
      s_wren_nxt    = 1'b0;
      enc_addr_nxt  = '0;
      dec_addr_nxt  = '0;
      dec_wdata_nxt = 8'd0;
      dec_wren_nxt  = 1'b0;

      case (state_nxt)
         RD_I: s_addr_nxt = i_nxt;
         RD_J: s_addr_nxt = j_nxt;
         WR_I: begin
            s_addr_nxt  = i_nxt;
            s_wdata_nxt = sj_nxt;
            s_wren_nxt  = 1'b1;
         end
         WR_J: begin
            s_addr_nxt  = j_nxt;
            s_wdata_nxt = si_nxt;
            s_wren_nxt  = 1'b1;
         end
         RD_F: begin
            s_addr_nxt   = si_nxt + sj_nxt;
            enc_addr_nxt = k_nxt;
         end
         WR_D: begin
            dec_addr_nxt  = k_nxt;
            dec_wdata_nxt = f_nxt ^ enc_byte_nxt;
            dec_wren_nxt  = 1'b1;
         end
         DONE: done_nxt = 1'b1;
         default: ;
      endcase
   end

   // State, working registers and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         i         <= 8'd0;
         j         <= 8'd0;
         k         <= '0;
         si        <= 8'd0;
         sj        <= 8'd0;
         f         <= 8'd0;
         enc_byte  <= 8'd0;
         done      <= 1'b0;
         s_addr    <= 8'd0;
         s_wdata   <= 8'd0;
         s_wren    <= 1'b0;
         enc_addr  <= '0;
         dec_addr  <= '0;
         dec_wdata <= 8'd0;
         dec_wren  <= 1'b0;
      end else begin
         state     <= state_nxt;
         i         <= i_nxt;
         j         <= j_nxt;
         k         <= k_nxt;
         si        <= si_nxt;
         sj        <= sj_nxt;
         f         <= f_nxt;
         enc_byte  <= enc_byte_nxt;
         done      <= done_nxt;
         s_addr    <= s_addr_nxt;
         s_wdata   <= s_wdata_nxt;
         s_wren    <= s_wren_nxt;
         enc_addr  <= enc_addr_nxt;
         dec_addr  <= dec_addr_nxt;
         dec_wdata <= dec_wdata_nxt;
         dec_wren  <= dec_wren_nxt;
      end
   end

endmodule
